// File: rtl/alu_sequencer.sv
// Request/response sequencer that drives an external ALU through B-load, execute and response phases.
// Optional macro ALU_SEQ_BCACHE_EN: cache the last loaded B and skip the load phase on a match.
module alu_sequencer (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [2:0] i_req_op,
    input  logic [7:0] i_req_a,
    input  logic [7:0] i_req_b,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic       o_alu_bWr,
    output logic       o_alu_oe,
    output logic       o_alu_subShiftDir,
    output logic [1:0] o_alu_aluOp,
    input  logic [7:0] i_alu_y,
    input  logic       i_alu_negative,
    input  logic       i_alu_zero,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_y,
    output logic       o_rsp_err,
    output logic       o_flag_n,
    output logic       o_flag_z
);

    // state | meaning
    // IDLE  | ready for a request, operands captured on accept
    // LOADB | write captured B into the ALU B register
    // EXEC  | ALU output enabled, result and flags sampled at end of cycle
    // RESP  | response presented until consumed
    typedef enum logic [1:0] {IDLE, LOADB, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       accept;
    logic       op_illegal;
    logic       bcache_hit;

    assign op_illegal = (i_req_op[2:1] == 2'b11);
    assign accept     = (state == IDLE) && i_req_valid;

`ifdef ALU_SEQ_BCACHE_EN
    logic [7:0] bcache_q;
    logic       bcache_vld;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bcache_q   <= '0;
            bcache_vld <= 1'b0;
        end else if (state == LOADB) begin
            bcache_q   <= b_q;
            bcache_vld <= 1'b1;
        end
    end

    assign bcache_hit = bcache_vld && (bcache_q == i_req_b);
`else
    assign bcache_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        o_req_ready       = 1'b0;
        o_alu_bWr         = 1'b0;
        o_alu_oe          = 1'b0;
        o_alu_aluOp       = 2'b00;
        o_alu_subShiftDir = 1'b0;
        o_rsp_valid       = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = !i_reset;
                if (i_req_valid) begin
                    if (op_illegal) begin
                        state_nxt = RESP;
                    end else if (bcache_hit) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = LOADB;
                    end
                end
            end
            LOADB: begin
                o_alu_bWr = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                o_alu_oe  = 1'b1;
                state_nxt = RESP;
                case (op_q)
                    3'b001: o_alu_subShiftDir = 1'b1;
                    3'b010: o_alu_aluOp = 2'b01;
                    3'b011: o_alu_aluOp = 2'b10;
                    3'b100: begin
                        o_alu_aluOp       = 2'b11;
                        o_alu_subShiftDir = 1'b1;
                    end
                    3'b101: o_alu_aluOp = 2'b11;
                    default: ;
                endcase
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Illegal ops answer straight from the accept edge; legal ops answer from the EXEC sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            o_rsp_y   <= '0;
            o_rsp_err <= 1'b0;
            o_flag_n  <= 1'b0;
            o_flag_z  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= i_req_op;
                a_q  <= i_req_a;
                b_q  <= i_req_b;
                if (op_illegal) begin
                    o_rsp_y   <= 8'h00;
                    o_rsp_err <= 1'b1;
                end
            end
            if (state == EXEC) begin
                o_rsp_y   <= i_alu_y;
                o_rsp_err <= 1'b0;
                o_flag_n  <= i_alu_negative;
                o_flag_z  <= i_alu_zero;
            end
        end
    end

    assign o_alu_a = a_q;
    assign o_alu_b = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, reset/cache sequences, random ops vs. a reference model.
module tb_alu_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [2:0] i_req_op;
    logic [7:0] i_req_a;
    logic [7:0] i_req_b;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic       o_alu_bWr;
    logic       o_alu_oe;
    logic       o_alu_subShiftDir;
    logic [1:0] o_alu_aluOp;
    logic [7:0] i_alu_y;
    logic       i_alu_negative;
    logic       i_alu_zero;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_y;
    logic       o_rsp_err;
    logic       o_flag_n;
    logic       o_flag_z;

    always #5 i_clk = ~i_clk;

    alu_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_bWr(o_alu_bWr), .o_alu_oe(o_alu_oe),
        .o_alu_subShiftDir(o_alu_subShiftDir), .o_alu_aluOp(o_alu_aluOp),
        .i_alu_y(i_alu_y), .i_alu_negative(i_alu_negative), .i_alu_zero(i_alu_zero),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_y(o_rsp_y), .o_rsp_err(o_rsp_err), .o_flag_n(o_flag_n), .o_flag_z(o_flag_z)
    );

    // External ALU: B register loaded by the write strobe, combinational result when enabled.
    logic [7:0] alu_breg;
    logic [7:0] alu_y_calc;

    always_ff @(posedge i_clk) begin
        if (o_alu_bWr) alu_breg <= o_alu_b;
    end

    always_comb begin
        alu_y_calc = 8'h00;
        if (o_alu_oe) begin
            case (o_alu_aluOp)
                2'b00: alu_y_calc = o_alu_subShiftDir ? (o_alu_a - alu_breg) : (o_alu_a + alu_breg);
                2'b01: alu_y_calc = o_alu_a & alu_breg;
                2'b10: alu_y_calc = o_alu_a ^ alu_breg;
                default: alu_y_calc = o_alu_subShiftDir ? (o_alu_a << alu_breg[2:0]) : (o_alu_a >> alu_breg[2:0]);
            endcase
        end
    end

    assign i_alu_y        = alu_y_calc;
    assign i_alu_negative = alu_y_calc[7];
    assign i_alu_zero     = (alu_y_calc == 8'h00);

`ifdef ALU_SEQ_BCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic       mflag_n = 1'b0;
    logic       mflag_z = 1'b0;
    logic       mcache_v = 1'b0;
    logic [7:0] mcache_b = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a ^ b;
            3'd4: return a << b[2:0];
            3'd5: return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    // {aluOp, subShiftDir} expected during EXEC
    function automatic logic [2:0] ref_ctl(input logic [2:0] op);
        case (op)
            3'd0: return 3'b000;
            3'd1: return 3'b001;
            3'd2: return 3'b010;
            3'd3: return 3'b100;
            3'd4: return 3'b111;
            3'd5: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                         input logic [7:0] ey, input logic eerr, input logic en, input logic ez);
        logic       legal;
        logic       hit;
        logic [2:0] ctl;
        int         exp_lat, lat, nbwr, noe, bad;
        legal   = (op[2:1] != 2'b11);
        hit     = CACHE_EN && legal && mcache_v && (mcache_b == b);
        exp_lat = !legal ? 1 : (hit ? 2 : 3);
        ctl     = ref_ctl(op);

        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_a     = a;
        i_req_b     = b;
        #1 check("req_ready", 32'(o_req_ready), 1);
        lat = 0; nbwr = 0; noe = 0; bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            if (o_rsp_valid) begin
                lat = c;
                break;
            end
            if (o_alu_bWr) begin
                nbwr++;
                if (o_alu_b !== b) bad++;
            end
            if (o_alu_oe) begin
                noe++;
                if (o_alu_a !== a || {o_alu_aluOp, o_alu_subShiftDir} !== ctl) bad++;
            end else if ({o_alu_aluOp, o_alu_subShiftDir} !== 3'b000) begin
                bad++;
            end
            if (o_req_ready) bad++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("bwr_pulses", 32'(nbwr), (legal && !hit) ? 1 : 0);
        check("oe_pulses", 32'(noe), legal ? 1 : 0);
        check("alu_ctl_bus", 32'(bad), 0);
        check("rsp_y", 32'(o_rsp_y), 32'(ey));
        check("rsp_err", 32'(o_rsp_err), 32'(eerr));
        check("flag_n", 32'(o_flag_n), 32'(en));
        check("flag_z", 32'(o_flag_z), 32'(ez));
        check("resp_strobes", 32'({o_alu_bWr, o_alu_oe, o_alu_aluOp, o_alu_subShiftDir}), 0);

        for (int h = 0; h < hold; h++) begin
            i_rsp_ready = 1'b0;
            i_req_valid = 1'b1;
            i_req_op    = 3'b000;
            i_req_a     = ~a;
            i_req_b     = ~b;
            @(negedge i_clk);
            check("hold_valid", 32'(o_rsp_valid), 1);
            check("hold_y", 32'(o_rsp_y), 32'(ey));
            check("hold_req_ready", 32'(o_req_ready), 0);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check("rsp_done", 32'(o_rsp_valid), 0);
        check("idle_ready", 32'(o_req_ready), 1);

        if (legal) begin
            mflag_n = en;
            mflag_z = ez;
            if (!hit) begin
                mcache_v = 1'b1;
                mcache_b = b;
            end
        end
    endtask

    task automatic rnd_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] ey;
        logic       legal;
        legal = (op[2:1] != 2'b11);
        ey    = legal ? ref_y(op, a, b) : 8'h00;
        do_op(op, a, b, hold, ey, !legal, legal ? ey[7] : mflag_n, legal ? (ey == 8'h00) : mflag_z);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] y;
        logic       err;
        logic       n;
        logic       z;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         seen_oe;
        int         stray;
        logic [7:0] last_b;

        vecs[0] = '{3'b000, 8'h05, 8'h03, 0, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 8'h5A, 8'h5A, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3'b110, 8'h12, 8'h34, 0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{3'b100, 8'h81, 8'h01, 0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'b101, 8'h80, 8'h07, 4, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'b010, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b001, 8'h03, 8'h05, 0, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{3'b111, 8'h77, 8'h66, 2, 8'h00, 1'b1, 1'b1, 1'b0};

        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_op    = 3'b000;
        i_req_a     = 8'h00;
        i_req_b     = 8'h00;
        i_rsp_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_req_ready", 32'(o_req_ready), 0);
        check("reset_outputs", 32'({o_rsp_valid, o_rsp_err, o_flag_n, o_flag_z, o_alu_bWr, o_alu_oe}), 0);
        check("reset_buses", 32'({o_alu_a, o_alu_b, o_rsp_y}), 0);
        i_reset = 1'b0;
        #1 check("post_reset_ready", 32'(o_req_ready), 1);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                  vecs[i].y, vecs[i].err, vecs[i].n, vecs[i].z);
        end

        // Reset while the ALU is enabled abandons the operation.
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_op    = 3'b000;
        i_req_a     = 8'h11;
        i_req_b     = 8'hC4;
        seen_oe = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            if (o_alu_oe) begin
                seen_oe = 1;
                break;
            end
        end
        check("reached_exec", 32'(seen_oe), 1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("mid_reset_ready", 32'(o_req_ready), 0);
        i_reset = 1'b0;
        #1;
        check("abort_ctl", 32'({o_rsp_valid, o_alu_bWr, o_alu_oe, o_alu_aluOp, o_alu_subShiftDir}), 0);
        check("abort_buses", 32'({o_alu_a, o_alu_b, o_rsp_y}), 0);
        check("abort_flags", 32'({o_rsp_err, o_flag_n, o_flag_z}), 0);
        check("abort_ready", 32'(o_req_ready), 1);
        stray = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_rsp_valid || o_alu_bWr || o_alu_oe) stray++;
        end
        check("abort_quiet", 32'(stray), 0);
        mflag_n  = 1'b0;
        mflag_z  = 1'b0;
        mcache_v = 1'b0;

        // Back-to-back ops sharing B: second one skips the load when the cache is built in.
        rnd_op(3'b000, 8'h01, 8'h03, 0);
        rnd_op(3'b001, 8'h09, 8'h03, 0);
        rnd_op(3'b011, 8'hC3, 8'h03, 1);

        last_b = 8'h03;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? last_b : 8'($urandom);
            rnd_op(op, a, b, int'($urandom_range(0, 2)));
            last_b = b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
